// File: rtl/timer_bank_if.sv
// timer_bank_if: CPU MEM-stage peripheral bus (rd/wr/addr/wdata/rdata).
//   master: drives rd, wr, addr, wdata; receives rdata.
//   slave : receives rd, wr, addr, wdata; drives combinational rdata.
interface timer_bank_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   modport master (output rd, wr, addr, wdata, input rdata);
   modport slave (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/timer_bank.sv
// timer_bank: bank of NUM_CH memory-mapped interval timers with a combined interrupt.
//   clk     : bus and timer clock
//   reset   : asynchronous, active-low reset
//   bus     : peripheral bus slave (rd/wr/addr/wdata/rdata); channel k at BASE_ADDR + 16*k
//             +0x0 TH reload, +0x4 TL counter, +0x8 TCON {oneshot,status,irq_en,en}, +0xC PSC
//   irqout  : OR of irq_vec
//   irq_vec : per-channel status & irq_en
// Optional prescaler enabled by defining TIMER_BANK_PRESCALE_EN; otherwise PSC reads 0.
module timer_bank #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_W     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h4000_1000
) (
   input  logic              clk,
   input  logic              reset,
   timer_bank_if.slave       bus,
   output logic              irqout,
   output logic [NUM_CH-1:0] irq_vec
);
   localparam logic [CNT_W-1:0] MAX  = '1;
   localparam logic [31:0]      SPAN = 32'(16 * NUM_CH);
   logic [31:0]      off;
   logic             hit;
   logic [2:0]       ch;
   logic [1:0]       rs;
   logic [CNT_W-1:0] th_q [NUM_CH];
   logic [CNT_W-1:0] th_d [NUM_CH];
   logic [CNT_W-1:0] tl_q [NUM_CH];
   logic [CNT_W-1:0] tl_d [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d, ie_q, ie_d, st_q, st_d, os_q, os_d;
   logic [NUM_CH-1:0] w_th, w_tl, w_tc, tick, tk, ovf;
   logic [15:0]      psc_v [NUM_CH];
`ifdef TIMER_BANK_PRESCALE_EN
   logic [NUM_CH-1:0] w_ps;
   logic [15:0]      psc_q [NUM_CH];
   logic [15:0]      psc_d [NUM_CH];
   logic [15:0]      div_q [NUM_CH];
   logic [15:0]      div_d [NUM_CH];
   assign psc_v = psc_q;
`else
   assign psc_v = '{default: '0};
`endif
   // Addresses below the base wrap to large offsets, so one unsigned compare bounds both ends.
   assign off = bus.addr - BASE_ADDR;
   assign hit = off < SPAN;
   assign ch  = off[6:4];
   assign rs  = off[3:2];
   assign irq_vec = st_q & ie_q;
   assign irqout  = |irq_vec;
   always_comb begin
      bus.rdata = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (bus.rd && hit && ch == 3'(k))
            bus.rdata = rs == 2'd0 ? 32'(th_q[k]) :
                        rs == 2'd1 ? 32'(tl_q[k]) :
                        rs == 2'd2 ? {28'd0, os_q[k], st_q[k], ie_q[k], en_q[k]} :
                                     {16'd0, psc_v[k]};
   end
   always_comb begin
      th_d = th_q;
      tl_d = tl_q;
      en_d = en_q;
      ie_d = ie_q;
      st_d = st_q;
      os_d = os_q;
      w_th = '0;
      w_tl = '0;
      w_tc = '0;
      tick = '0;
      tk   = '0;
      ovf  = '0;
`ifdef TIMER_BANK_PRESCALE_EN
      w_ps  = '0;
      psc_d = psc_q;
      div_d = div_q;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
         w_th[k] = bus.wr && hit && ch == 3'(k) && rs == 2'd0;
         w_tl[k] = bus.wr && hit && ch == 3'(k) && rs == 2'd1;
         w_tc[k] = bus.wr && hit && ch == 3'(k) && rs == 2'd2;
`ifdef TIMER_BANK_PRESCALE_EN
         w_ps[k] = bus.wr && hit && ch == 3'(k) && rs == 2'd3;
         tick[k] = en_q[k] && div_q[k] == psc_q[k];
         psc_d[k] = w_ps[k] ? bus.wdata[15:0] : psc_q[k];
         div_d[k] = (w_ps[k] || w_tc[k] || !en_q[k] || tick[k]) ? 16'd0 : div_q[k] + 16'd1;
`else
         tick[k] = en_q[k];
`endif
         // A CPU write to TL, or a TCON write that disables, pre-empts this cycle's tick entirely.
         tk[k]   = tick[k] && !w_tl[k] && !(w_tc[k] && !bus.wdata[0]);
         ovf[k]  = tk[k] && tl_q[k] == MAX;
         th_d[k] = w_th[k] ? bus.wdata[CNT_W-1:0] : th_q[k];
         tl_d[k] = w_tl[k] ? bus.wdata[CNT_W-1:0] : ovf[k] ? th_q[k] : tk[k] ? tl_q[k] + CNT_W'(1) : tl_q[k];
         en_d[k] = w_tc[k] ? bus.wdata[0] : (ovf[k] && os_q[k]) ? 1'b0 : en_q[k];
         ie_d[k] = w_tc[k] ? bus.wdata[1] : ie_q[k];
         os_d[k] = w_tc[k] ? bus.wdata[3] : os_q[k];
         // Overflow set dominates a same-cycle write-1-to-clear.
         st_d[k] = ovf[k] || (st_q[k] && !(w_tc[k] && bus.wdata[2]));
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            th_q[k] <= '0;
            tl_q[k] <= '0;
`ifdef TIMER_BANK_PRESCALE_EN
            psc_q[k] <= '0;
            div_q[k] <= '0;
`endif
         end
         en_q <= '0;
         ie_q <= '0;
         st_q <= '0;
         os_q <= '0;
      end else begin
         th_q <= th_d;
         tl_q <= tl_d;
`ifdef TIMER_BANK_PRESCALE_EN
         psc_q <= psc_d;
         div_q <= div_d;
`endif
         en_q <= en_d;
         ie_q <= ie_d;
         st_q <= st_d;
         os_q <= os_d;
      end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed stimulus with a read scoreboard for timer_bank.
module tb_timer_bank;
   localparam logic [31:0] B = 32'h4000_1000;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       irqout;
   logic [3:0] irq_vec;
   int         n_chk = 0;
   int         n_fail = 0;
   typedef struct {
      string       name;
      logic [31:0] d;
      logic [3:0]  v;
   } exp_t;
   exp_t q[$];

   timer_bank_if bus();
   timer_bank dut (.clk(clk), .reset(reset), .bus(bus), .irqout(irqout), .irq_vec(irq_vec));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      exp_t e;
      if (bus.rd) begin
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: rdata=%h irq_vec=%b with no expectation queued", bus.rdata, irq_vec);
         end else begin
            e = q.pop_front();
            if (bus.rdata !== e.d || irq_vec !== e.v || irqout !== (|e.v)) begin
               n_fail++;
               $display("FAIL %s: got rdata=%h irq_vec=%b irqout=%b, expected rdata=%h irq_vec=%b irqout=%b",
                        e.name, bus.rdata, irq_vec, irqout, e.d, e.v, |e.v);
            end
         end
      end
   end

   task automatic op_wr(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      bus.wr = 1'b1;
      bus.addr = a;
      bus.wdata = d;
   endtask

   task automatic op_rd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] v, input string n);
      @(posedge clk);
      #1;
      q.push_back(exp_t'{n, d, v});
      bus.wr = 1'b0;
      bus.rd = 1'b1;
      bus.addr = a;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] psc_tl [9];
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            op_rd(B + 32'(16 * c + 4 * r), 32'd0, 4'b0000, "reset_reg");
      op_rd(B + 32'd64, 32'd0, 4'b0000, "out_of_range_high");
      // channel 0: periodic, period 4
      op_wr(B + 32'h0, 32'hFFFF_FFFC);
      op_wr(B + 32'h4, 32'hFFFF_FFFC);
      op_wr(B + 32'h8, 32'h3);
      op_rd(B + 32'h4, 32'hFFFF_FFFC, 4'b0000, "ch0_tl_e0");
      op_rd(B + 32'h4, 32'hFFFF_FFFD, 4'b0000, "ch0_tl_e1");
      op_rd(B + 32'h4, 32'hFFFF_FFFE, 4'b0000, "ch0_tl_e2");
      op_rd(B + 32'h4, 32'hFFFF_FFFF, 4'b0000, "ch0_tl_e3");
      op_rd(B + 32'h4, 32'hFFFF_FFFC, 4'b0001, "ch0_reload_irq");
      op_rd(B + 32'h8, 32'h7, 4'b0001, "ch0_tcon_pending");
      op_wr(B + 32'h8, 32'h7);
      op_rd(B + 32'h8, 32'h3, 4'b0000, "ch0_w1c");
      op_rd(B + 32'h8, 32'h7, 4'b0001, "ch0_second_irq");
      op_wr(B + 32'h8, 32'h0);
      op_rd(B + 32'h8, 32'h4, 4'b0000, "ch0_masked_status_kept");
      op_rd(B + 32'h4, 32'hFFFF_FFFD, 4'b0000, "ch0_disable_no_tick");
      op_rd(B - 32'd16, 32'd0, 4'b0000, "out_of_range_low");
`ifndef TIMER_BANK_PRESCALE_EN
      op_wr(B + 32'hC, 32'h3);
      op_rd(B + 32'hC, 32'd0, 4'b0000, "psc_absent");
`endif
      // channel 1: one-shot
      op_wr(B + 32'h10, 32'h0);
      op_wr(B + 32'h14, 32'hFFFF_FFFE);
      op_wr(B + 32'h18, 32'hB);
      op_rd(B + 32'h14, 32'hFFFF_FFFE, 4'b0000, "ch1_tl_f0");
      op_rd(B + 32'h14, 32'hFFFF_FFFF, 4'b0000, "ch1_tl_f1");
      op_rd(B + 32'h14, 32'h0, 4'b0010, "ch1_oneshot_ovf");
      op_rd(B + 32'h18, 32'hE, 4'b0010, "ch1_en_cleared");
      op_rd(B + 32'h14, 32'h0, 4'b0010, "ch1_tl_holds");
      op_wr(B + 32'h18, 32'h6);
      op_rd(B + 32'h18, 32'h2, 4'b0000, "ch1_w1c");
      // channel 2: W1C colliding with overflow, then disable at overflow
      op_wr(B + 32'h20, 32'hFFFF_FFFC);
      op_wr(B + 32'h24, 32'hFFFF_FFFE);
      op_wr(B + 32'h28, 32'h3);
      op_rd(B + 32'h24, 32'hFFFF_FFFE, 4'b0000, "ch2_tl_g0");
      op_wr(B + 32'h28, 32'h7);
      op_rd(B + 32'h28, 32'h7, 4'b0100, "ch2_set_beats_w1c");
      op_wr(B + 32'h28, 32'h7);
      op_rd(B + 32'h28, 32'h3, 4'b0000, "ch2_w1c_later");
      op_wr(B + 32'h28, 32'h0);
      op_rd(B + 32'h28, 32'h0, 4'b0000, "ch2_disable_no_ovf");
      op_rd(B + 32'h24, 32'hFFFF_FFFF, 4'b0000, "ch2_tl_frozen");
      // channel 3: TL write at the overflow edge, then async reset
      op_wr(B + 32'h30, 32'h0);
      op_wr(B + 32'h34, 32'hFFFF_FFFD);
      op_wr(B + 32'h38, 32'h3);
      op_rd(B + 32'h34, 32'hFFFF_FFFD, 4'b0000, "ch3_tl_h0");
      op_rd(B + 32'h34, 32'hFFFF_FFFE, 4'b0000, "ch3_tl_h1");
      op_wr(B + 32'h34, 32'h10);
      op_rd(B + 32'h34, 32'h10, 4'b0000, "ch3_tl_write_wins");
      op_rd(B + 32'h38, 32'h3, 4'b0000, "ch3_no_status");
      op_rd(B + 32'h34, 32'h12, 4'b0000, "ch3_counting");
      op_wr(B + 32'h8, 32'h2);
      op_rd(B + 32'h8, 32'h6, 4'b0001, "ch0_unmask");
      @(posedge clk);
      #1;
      reset = 1'b0;
      q.push_back(exp_t'{"async_reset_tl", 32'd0, 4'b0000});
      bus.addr = B + 32'h34;
      op_rd(B + 32'h8, 32'd0, 4'b0000, "reset_held_tcon");
      @(posedge clk);
      #1;
      reset = 1'b1;
      bus.rd = 1'b0;
      op_rd(B + 32'h34, 32'd0, 4'b0000, "ch3_stays_idle");
      op_rd(B + 32'h38, 32'd0, 4'b0000, "ch3_tcon_after_reset");
`ifdef TIMER_BANK_PRESCALE_EN
      psc_tl = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      op_wr(B + 32'hC, 32'h3);
      op_wr(B + 32'h0, 32'hFFFF_FFFE);
      op_wr(B + 32'h4, 32'hFFFF_FFFE);
      op_wr(B + 32'h8, 32'h5);
      for (int i = 0; i < 9; i++)
         op_rd(B + 32'h4, psc_tl[i], 4'b0000, "psc_tl");
      op_rd(B + 32'h8, 32'h5, 4'b0000, "psc_ovf_status");
      op_rd(B + 32'hC, 32'h3, 4'b0000, "psc_readback");
`else
      psc_tl = '{default: '0};
`endif
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      repeat (2) @(posedge clk);
      n_chk++;
      if (q.size() != 0 || psc_tl[0] === 32'hx) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
